// File: rtl/mem_access_if.sv
// Data-memory request/response bus between the MEM pipeline stage and data memory.
// The master side issues requests; the slave side answers with ack and read data.
interface mem_access_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_access.sv
// MEM pipeline stage: retires ALU ops in one cycle, runs one outstanding data-memory
// request at a time with flush draining and a watchdog that flags lost acknowledgements.
module mem_access (
    input  logic         clk,
    input  logic         rst,
    input  logic         ex_valid,
    input  logic         exe_write_reg,
    input  logic         exe_mem_to_reg,
    input  logic         exe_write_mem,
    input  logic [4:0]   exe_rn,
    input  logic [31:0]  alu_result,
    input  logic [31:0]  store_data,
    input  logic         flush,
    output logic         stall,
    mem_access_if.master bus,
    output logic         wb_valid,
    output logic         wb_write_reg,
    output logic [4:0]   wb_rn,
    output logic [31:0]  wb_data,
    output logic         mem_err
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Expire on the ack-less cycle that would take the count to 255.
    localparam logic [7:0] WDOG_LAST = 8'd254;

    state_t      state_r;
    logic [7:0]  wdog_r;
    logic        mem_req_r;
    logic        mem_we_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_wdata_r;
    logic [4:0]  rn_r;
    logic        wb_valid_r;
    logic        wb_write_reg_r;
    logic [4:0]  wb_rn_r;
    logic [31:0] wb_data_r;
    logic        mem_err_r;
    logic        is_mem_op_s;

    // A set store bit wins over the load bit, so either one makes this a memory op.
    assign is_mem_op_s = exe_mem_to_reg | exe_write_mem;

    // Pipeline control: request issue, completion, flush draining and watchdog expiry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= IDLE;
            wdog_r         <= 8'd0;
            mem_req_r      <= 1'b0;
            mem_we_r       <= 1'b0;
            mem_addr_r     <= 32'd0;
            mem_wdata_r    <= 32'd0;
            rn_r           <= 5'd0;
            wb_valid_r     <= 1'b0;
            wb_write_reg_r <= 1'b0;
            wb_rn_r        <= 5'd0;
            wb_data_r      <= 32'd0;
            mem_err_r      <= 1'b0;
        end else begin
            wb_valid_r     <= 1'b0;
            wb_write_reg_r <= 1'b0;
            wb_rn_r        <= 5'd0;
            wb_data_r      <= 32'd0;
            case (state_r)
                IDLE: begin
                    if (ex_valid && !flush) begin
                        if (is_mem_op_s) begin
                            mem_req_r   <= 1'b1;
                            mem_we_r    <= exe_write_mem;
                            mem_addr_r  <= alu_result;
                            mem_wdata_r <= store_data;
                            rn_r        <= exe_rn;
                            wdog_r      <= 8'd0;
                            state_r     <= BUSY;
                        end else begin
                            wb_valid_r     <= 1'b1;
                            wb_write_reg_r <= exe_write_reg;
                            wb_rn_r        <= exe_rn;
                            wb_data_r      <= alu_result;
                        end
                    end
                end
                BUSY: begin
                    if (bus.mem_ack) begin
                        mem_req_r   <= 1'b0;
                        mem_we_r    <= 1'b0;
                        mem_addr_r  <= 32'd0;
                        mem_wdata_r <= 32'd0;
                        state_r     <= IDLE;
                        if (!flush) begin
                            wb_valid_r     <= 1'b1;
                            wb_write_reg_r <= ~mem_we_r;
                            wb_rn_r        <= rn_r;
                            wb_data_r      <= mem_we_r ? 32'd0 : bus.mem_rdata;
                        end
                    end else if (flush) begin
                        wdog_r  <= 8'd0;
                        state_r <= DRAIN;
                    end else if (wdog_r == WDOG_LAST) begin
                        mem_req_r   <= 1'b0;
                        mem_we_r    <= 1'b0;
                        mem_addr_r  <= 32'd0;
                        mem_wdata_r <= 32'd0;
                        mem_err_r   <= 1'b1;
                        wdog_r      <= wdog_r + 8'd1;
                        state_r     <= IDLE;
                    end else begin
                        wdog_r <= wdog_r + 8'd1;
                    end
                end
                DRAIN: begin
                    // The request stays on the bus so a squashed store still lands in memory.
                    if (bus.mem_ack) begin
                        mem_req_r   <= 1'b0;
                        mem_we_r    <= 1'b0;
                        mem_addr_r  <= 32'd0;
                        mem_wdata_r <= 32'd0;
                        state_r     <= IDLE;
                    end else if (wdog_r == WDOG_LAST) begin
                        mem_req_r   <= 1'b0;
                        mem_we_r    <= 1'b0;
                        mem_addr_r  <= 32'd0;
                        mem_wdata_r <= 32'd0;
                        mem_err_r   <= 1'b1;
                        wdog_r      <= wdog_r + 8'd1;
                        state_r     <= IDLE;
                    end else begin
                        wdog_r <= wdog_r + 8'd1;
                    end
                end
                default: begin
                    mem_req_r <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    assign stall         = (state_r != IDLE);
    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign wb_valid      = wb_valid_r;
    assign wb_write_reg  = wb_write_reg_r;
    assign wb_rn         = wb_rn_r;
    assign wb_data       = wb_data_r;
    assign mem_err       = mem_err_r;
endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed scenarios with literal expectations, then random traffic,
// all checked every cycle against a transaction-level model of the stage.
module tb_mem_access;
    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, exe_write_reg, exe_mem_to_reg, exe_write_mem, flush;
    logic [4:0]  exe_rn;
    logic [31:0] alu_result, store_data;
    logic        stall, wb_valid, wb_write_reg, mem_err;
    logic [4:0]  wb_rn;
    logic [31:0] wb_data;

    mem_access_if bus();

    mem_access dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .exe_write_reg(exe_write_reg),
        .exe_mem_to_reg(exe_mem_to_reg), .exe_write_mem(exe_write_mem), .exe_rn(exe_rn),
        .alu_result(alu_result), .store_data(store_data), .flush(flush), .stall(stall),
        .bus(bus), .wb_valid(wb_valid), .wb_write_reg(wb_write_reg), .wb_rn(wb_rn),
        .wb_data(wb_data), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: at most one outstanding memory transaction plus the retirement it produces.
    bit          m_open, m_store, m_killed, m_err;
    logic [4:0]  m_rn;
    logic [31:0] m_addr, m_wdata;
    int          m_wait;
    bit          e_wbv, e_wbw;
    logic [4:0]  e_rn;
    logic [31:0] e_wbd;

    task automatic chkb(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkw(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_open = 1'b0; m_store = 1'b0; m_killed = 1'b0; m_err = 1'b0;
        m_rn = 5'd0; m_addr = 32'd0; m_wdata = 32'd0; m_wait = 0;
        e_wbv = 1'b0; e_wbw = 1'b0; e_rn = 5'd0; e_wbd = 32'd0;
    endtask

    task automatic model_edge();
        e_wbv = 1'b0; e_wbw = 1'b0; e_rn = 5'd0; e_wbd = 32'd0;
        if (!rst) begin
            model_reset();
        end else if (m_open) begin
            if (bus.mem_ack) begin
                if (!m_killed && !flush) begin
                    e_wbv = 1'b1;
                    e_wbw = !m_store;
                    e_rn  = m_rn;
                    e_wbd = m_store ? 32'd0 : bus.mem_rdata;
                end
                m_open = 1'b0;
            end else if (flush && !m_killed) begin
                m_killed = 1'b1;
                m_wait   = 0;
            end else begin
                m_wait++;
                if (m_wait == 255) begin
                    m_open = 1'b0;
                    m_err  = 1'b1;
                end
            end
        end else if (ex_valid && !flush) begin
            if (exe_mem_to_reg || exe_write_mem) begin
                m_open   = 1'b1;
                m_store  = exe_write_mem;
                m_killed = 1'b0;
                m_wait   = 0;
                m_rn     = exe_rn;
                m_addr   = alu_result;
                m_wdata  = store_data;
            end else begin
                e_wbv = 1'b1;
                e_wbw = exe_write_reg;
                e_rn  = exe_rn;
                e_wbd = alu_result;
            end
        end
    endtask

    task automatic compare();
        chkb("stall", stall, m_open);
        chkb("mem_req", bus.mem_req, m_open);
        chkb("mem_err", mem_err, m_err);
        chkb("wb_valid", wb_valid, e_wbv);
        chkb("wb_write_reg", wb_write_reg, e_wbw);
        chkw("wb_rn", {27'd0, wb_rn}, {27'd0, e_rn});
        chkw("wb_data", wb_data, e_wbd);
        if (m_open) begin
            chkb("mem_we", bus.mem_we, m_store);
            chkw("mem_addr", bus.mem_addr, m_addr);
            chkw("mem_wdata", bus.mem_wdata, m_wdata);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic set_idle();
        ex_valid = 1'b0; exe_write_reg = 1'b0; exe_mem_to_reg = 1'b0; exe_write_mem = 1'b0;
        exe_rn = 5'd0; alu_result = 32'd0; store_data = 32'd0; flush = 1'b0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0;
    endtask

    task automatic issue(input logic wr, input logic ld, input logic st, input logic [4:0] rn,
                         input logic [31:0] alu, input logic [31:0] sd);
        ex_valid = 1'b1; exe_write_reg = wr; exe_mem_to_reg = ld; exe_write_mem = st;
        exe_rn = rn; alu_result = alu; store_data = sd;
    endtask

    initial begin
        int hi;
        rst = 1'b0;
        set_idle();
        model_reset();
        cycle();
        cycle();
        chkb("rst_stall", stall, 1'b0);
        chkb("rst_req", bus.mem_req, 1'b0);
        chkw("rst_addr", bus.mem_addr, 32'd0);
        chkb("rst_wbv", wb_valid, 1'b0);

        // ALU op presented as reset releases: accepted on the very next edge.
        rst = 1'b1;
        issue(1'b1, 1'b0, 1'b0, 5'd5, 32'h0000_1234, 32'd0);
        cycle();
        set_idle();
        chkb("alu_wbv", wb_valid, 1'b1);
        chkw("alu_rn", {27'd0, wb_rn}, 32'd5);
        chkw("alu_data", wb_data, 32'h0000_1234);
        chkb("alu_stall", stall, 1'b0);
        cycle();
        chkb("alu_pulse", wb_valid, 1'b0);

        // Load acknowledged in its third busy cycle.
        issue(1'b1, 1'b1, 1'b0, 5'd7, 32'h0000_0100, 32'd0);
        cycle();
        set_idle();
        chkw("ld_addr", bus.mem_addr, 32'h0000_0100);
        chkb("ld_we", bus.mem_we, 1'b0);
        hi = 0;
        for (int i = 1; i <= 3; i++) begin
            hi += (bus.mem_req && stall) ? 1 : 0;
            if (i == 3) begin
                bus.mem_ack = 1'b1;
                bus.mem_rdata = 32'hDEAD_BEEF;
            end
            cycle();
        end
        set_idle();
        chkw("ld_busy_cycles", hi, 32'd3);
        chkb("ld_wbv", wb_valid, 1'b1);
        chkw("ld_data", wb_data, 32'hDEAD_BEEF);
        chkb("ld_wbw", wb_write_reg, 1'b1);
        chkb("ld_req_off", bus.mem_req, 1'b0);
        chkb("ld_stall_off", stall, 1'b0);
        cycle();
        chkb("ld_pulse", wb_valid, 1'b0);

        // Store acknowledged in its second busy cycle.
        issue(1'b0, 1'b0, 1'b1, 5'd9, 32'h0000_0040, 32'h0000_00A5);
        cycle();
        set_idle();
        chkb("st_we", bus.mem_we, 1'b1);
        chkw("st_wdata", bus.mem_wdata, 32'h0000_00A5);
        cycle();
        chkw("st_wdata_hold", bus.mem_wdata, 32'h0000_00A5);
        bus.mem_ack = 1'b1;
        cycle();
        set_idle();
        chkb("st_wbv", wb_valid, 1'b1);
        chkb("st_wbw", wb_write_reg, 1'b0);
        chkw("st_data", wb_data, 32'd0);

        // Flush on the second busy cycle of a load, ack on the fourth.
        issue(1'b1, 1'b1, 1'b0, 5'd4, 32'h0000_0200, 32'd0);
        cycle();
        set_idle();
        cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chkb("fl_req_held", bus.mem_req, 1'b1);
        chkb("fl_stall", stall, 1'b1);
        cycle();
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'h1111_1111;
        cycle();
        set_idle();
        chkb("fl_wbv", wb_valid, 1'b0);
        chkb("fl_req_off", bus.mem_req, 1'b0);
        chkb("fl_stall_off", stall, 1'b0);

        // Load that is never acknowledged trips the watchdog after 255 waiting cycles.
        issue(1'b1, 1'b1, 1'b0, 5'd2, 32'h0000_0300, 32'd0);
        cycle();
        set_idle();
        for (int i = 0; i < 254; i++) cycle();
        chkb("to_req_before", bus.mem_req, 1'b1);
        cycle();
        chkb("to_req", bus.mem_req, 1'b0);
        chkb("to_err", mem_err, 1'b1);
        chkb("to_stall", stall, 1'b0);
        chkb("to_wbv", wb_valid, 1'b0);
        issue(1'b1, 1'b0, 1'b0, 5'd3, 32'h0000_0055, 32'd0);
        cycle();
        set_idle();
        chkb("to_alu_wbv", wb_valid, 1'b1);
        chkw("to_alu_data", wb_data, 32'h0000_0055);
        chkb("to_err_sticky", mem_err, 1'b1);

        // Asynchronous reset in the middle of a load.
        issue(1'b1, 1'b1, 1'b0, 5'd8, 32'h0000_0400, 32'd0);
        cycle();
        set_idle();
        cycle();
        #2 rst = 1'b0;
        model_reset();
        #1;
        chkb("mr_req", bus.mem_req, 1'b0);
        chkb("mr_stall", stall, 1'b0);
        chkb("mr_err", mem_err, 1'b0);
        chkw("mr_addr", bus.mem_addr, 32'd0);
        compare();
        @(negedge clk);
        rst = 1'b1;
        issue(1'b1, 1'b0, 1'b0, 5'd6, 32'h0000_BEEF, 32'd0);
        cycle();
        set_idle();
        chkb("mr_alu_wbv", wb_valid, 1'b1);
        chkw("mr_alu_data", wb_data, 32'h0000_BEEF);

        // Random traffic: mixed ops, random ack latency, stray acks, flushes.
        for (int n = 0; n < 4000; n++) begin
            ex_valid       = ($urandom_range(0, 3) != 0);
            exe_write_reg  = 1'($urandom_range(0, 1));
            exe_mem_to_reg = ($urandom_range(0, 2) == 0);
            exe_write_mem  = ($urandom_range(0, 2) == 0);
            exe_rn         = 5'($urandom);
            alu_result     = $urandom;
            store_data     = $urandom;
            flush          = ($urandom_range(0, 9) == 0);
            bus.mem_ack    = m_open ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            bus.mem_rdata  = $urandom;
            cycle();
        end
        set_idle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset.
REQ-003 ex_valid  in  1  EX stage presents a valid instruction this cycle.
REQ-004 exe_write_reg  in  1  instruction writes a register.
REQ-005 exe_mem_to_reg  in  1  instruction is a load.
REQ-006 exe_write_mem  in  1  instruction is a store.
REQ-007 exe_rn  in  5  destination register number.
REQ-008 alu_result  in  32  ALU output; memory address for load/store, writeback data otherwise.
REQ-009 store_data  in  32  store operand (oprand_2 path).
REQ-010 flush  in  1  squash the current and in-flight instruction.
REQ-011 stall  out  1  EX/ID must hold its registers.
REQ-012 mem_req, mem_we  out  1,1  data memory request and write enable.
REQ-013 mem_addr, mem_wdata  out  32,32  request address and write data.
REQ-014 mem_ack  in  1  memory completes the request; mem_rdata is valid in the same cycle.
REQ-015 mem_rdata  in  32  load data.
REQ-016 wb_valid, wb_write_reg  out  1,1  WB stage valid and register-write enable.
REQ-017 wb_rn, wb_data  out  5,32  WB destination register and data.
REQ-018 mem_err  out  1  sticky flag set when a memory request times out.

Function
REQ-019 FSM states: IDLE, BUSY, DRAIN. Reset state is IDLE.
REQ-020 IDLE, ex_valid=1, flush=0, non-memory op (load=0, store=0): next cycle wb_valid=1, wb_write_reg=exe_write_reg, wb_rn=exe_rn, wb_data=alu_result. Latency is 1 cycle.
REQ-021 IDLE, ex_valid=1, flush=0, load or store: on the same edge, register mem_req=1, mem_we=exe_write_mem, mem_addr=alu_result, mem_wdata=store_data, plus rn and write_reg; go to BUSY; wb_valid=0 next cycle.
REQ-022 exe_mem_to_reg and exe_write_mem both 1: treat as a store; the load side is ignored.
REQ-023 stall is combinational and equals 1 whenever the state is BUSY or DRAIN; it is 0 in IDLE.
REQ-024 BUSY: mem_req and the request fields stay stable until mem_ack. On mem_ack: mem_req=0 next cycle, go to IDLE, and produce wb_valid=1 for exactly one cycle.
REQ-025 Load completion: wb_write_reg=1, wb_data=mem_rdata captured at the ack edge.
REQ-026 Store completion: wb_write_reg=0, wb_data=0.
REQ-027 wb_valid is a single-cycle pulse per retired instruction; all wb_* outputs are 0 whenever wb_valid=0.
REQ-028 flush in IDLE: the EX instruction is dropped, with no request and no wb_valid.
REQ-029 flush in BUSY: go to DRAIN. mem_req is held until mem_ack; on ack, go to IDLE with no wb_valid. A store still completes in memory.
REQ-030 flush together with mem_ack in BUSY: discard the result, no wb_valid, go to IDLE.
REQ-031 Watchdog: an 8-bit counter clears on entry to BUSY/DRAIN and increments each cycle without mem_ack.
REQ-032 Watchdog expiry: at count 255 with no ack, drop mem_req, set mem_err=1, go to IDLE, no wb_valid.
REQ-033 mem_err remains 1 until reset.
REQ-034 ex_valid in BUSY/DRAIN is ignored; upstream holds it under stall.

Reset
REQ-035 rst=0 forces asynchronously: state=IDLE, counter=0, and mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_write_reg, wb_rn, wb_data, mem_err all 0.
REQ-036 Reset mid-transaction abandons the request with no completion.
REQ-037 After rst rises, the first instruction is accepted on the next edge.

Verification
REQ-038 ALU op: ex_valid=1, write_reg=1, rn=5, alu_result=0x1234 -> next cycle wb_valid=1, wb_rn=5, wb_data=0x1234; stall=0 throughout.
REQ-039 Load: addr=0x100, ack after 3 cycles with rdata=0xDEADBEEF -> mem_req high 3 cycles, stall high 3 cycles, then one wb_valid pulse with wb_data=0xDEADBEEF.
REQ-040 Store: addr=0x40, data=0xA5 -> mem_we=1, mem_wdata=0xA5 until ack; completion pulse shows wb_write_reg=0.
REQ-041 Flush: flush asserted on the second BUSY cycle of a load, ack on the fourth -> mem_req held until ack, no wb_valid, stall deasserted after ack.
REQ-042 Timeout: load with ack never asserted -> after 255 wait cycles mem_req=0, mem_err=1, stall=0; the next ALU op retires normally.
REQ-043 Reset mid-BUSY: rst=0 during a load -> all outputs 0 immediately; a post-reset ALU op retires in 1 cycle.
